// File: rtl/fifo_control.sv
// Pointer, occupancy and flag controller for one dual-port FIFO memory.
// The memory registers its read data, so popped words appear one cycle after read_enable.
module fifo_control #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] FIFO_data_in,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  write_enable,
  output logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_TH_C = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_TH_C = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

  logic push_ok;
  logic pop_ok;
  logic reject;

  // Handshake: a push is taken in any cycle where push=1 and full=0, a pop where
  // pop=1 and empty=0; there is no stall, a refused request is dropped and flagged.
  always_comb begin
    push_ok      = push & ~full;
    pop_ok       = pop & ~empty;
    reject       = (push & full) | (pop & empty);
    write_enable = push_ok & reset_L;
    read_enable  = pop_ok & reset_L;
    FIFO_data_in = data_in;
    data_out     = FIFO_data_out;
  end

  always_comb begin
    full         = (count == DEPTH_C);
    empty        = (count == '0);
    almost_full  = (count >= AF_TH_C);
    almost_empty = (count <= AE_TH_C);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (write_enable) wr_ptr <= wr_ptr + 1'b1;
      if (read_enable)  rd_ptr <= rd_ptr + 1'b1;
      case ({write_enable, read_enable})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      valid_out <= read_enable;
      if (reject) error <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_control.md
Name: fifo_control

Overview:
- Pointer and flag controller that drives the dual-port FIFO memory's write and read ports.
- Generates `wr_ptr`, `rd_ptr`, `write_enable`, `read_enable` and forwards write data to the memory.
- Gives the user side a push/pop interface with full/empty/almost flags, an occupancy count and a sticky error flag.
- Pairs 1:1 with the memory block; together they form one FIFO instance.

Parameters:
- DATA_WIDTH, 8, width of data words.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries.
- ALMOST_FULL_TH, 6, `almost_full` asserted when count >= this value.
- ALMOST_EMPTY_TH, 2, `almost_empty` asserted when count <= this value.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- push  input  1  user write request.
- pop  input  1  user read request.
- data_in  input  DATA_WIDTH  user write data.
- data_out  output  DATA_WIDTH  user read data (= FIFO_data_out).
- valid_out  output  1  data_out holds popped word this cycle.
- FIFO_data_in  output  DATA_WIDTH  memory write data.
- wr_ptr  output  ADDR_WIDTH  memory write address.
- rd_ptr  output  ADDR_WIDTH  memory read address.
- write_enable  output  1  memory write strobe.
- read_enable  output  1  memory read strobe.
- FIFO_data_out  input  DATA_WIDTH  memory read data, registered in memory, 1-cycle latency.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  output  1  status flags.
- error  output  1  sticky overflow/underflow indicator.

Behaviour:
- Memory contract:
  - Memory writes `FIFO_data_in` at `wr_ptr` on posedge when `write_enable` is high.
  - Memory presents mem[`rd_ptr`] on `FIFO_data_out` after the posedge where `read_enable` is high.
- Reset (`reset_L` low, asynchronous, also mid-operation):
  - wr_ptr=0, rd_ptr=0, count=0, valid_out=0, error=0.
  - empty=1, full=0, almost_full=0, almost_empty=1.
  - write_enable and read_enable are gated to 0 combinationally while `reset_L` is low.
  - Any in-flight pop is discarded; no valid_out follows reset release.
- Accept logic (combinational from current state):
  - push_ok = push & ~full.
  - pop_ok = pop & ~empty.
  - write_enable = push_ok; read_enable = pop_ok.
  - FIFO_data_in = data_in (passthrough).
- Pointer update on posedge:
  - wr_ptr += push_ok; rd_ptr += pop_ok.
  - Natural modulo-DEPTH wrap: DEPTH-1 -> 0, no extra wrap bit in pointers.
- Count update on posedge:
  - push_ok only: +1. pop_ok only: -1. Both or neither: unchanged.
- Flags derived from registered count:
  - full = (count==DEPTH); empty = (count==0).
  - almost_full = (count>=ALMOST_FULL_TH); almost_empty = (count<=ALMOST_EMPTY_TH).
- Boundary conditions:
  - Push when full: ignored (no write, no pointer move); error set.
  - Pop when empty: ignored; error set.
  - Push and pop simultaneously on empty: push accepted, pop rejected, error set; count -> 1.
  - Push and pop simultaneously on full: pop accepted, push rejected, error set; count -> DEPTH-1.
  - No bypass path; a word is readable no earlier than the cycle after it was written.
  - Push and pop simultaneously on neither full nor empty: both accepted, count unchanged.
  - error stays 1 until reset.
- Read latency:
  - pop_ok at posedge N gives valid_out=1 during cycle N..N+1.
  - data_out = FIFO_data_out in that cycle.
  - valid_out is a register loaded with pop_ok each posedge.
  - Back-to-back pops give one word per cycle.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, count=0, wr_ptr=rd_ptr=0, write_enable=read_enable=0, error=0.
- Push 0xFF,0xAF,0x17 on consecutive cycles, then pop 3 -> writes at wr_ptr 0,1,2; valid_out for 3 cycles with data_out 0xFF,0xAF,0x17; count returns to 0, empty=1.
- Push 8 words 0x10..0x17 -> count hits 6 and almost_full=1; at count 8 full=1; a 9th push -> write_enable=0, wr_ptr stays 0 (wrapped), error=1.
- With count=4, hold push=pop=1 for 10 cycles -> count stays 4; pointers wrap past 7->0; data_out order matches push order.
- Pop on empty with push=1 -> count=1, read_enable=0, valid_out stays 0, error=1.
- Drop reset_L mid-burst, asynchronously, between clock edges -> all outputs return to reset values immediately; after release, valid_out=0 and first push writes at address 0.
